// File: rtl/jtag_mem_arbiter_pkg.sv
// Shared types for the JTAG host / engine memory arbiter: FSM states,
// host op encoding and requester indices into the round-robin arbiter.
package jtag_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ISSUE_HOST   = 2'd1,
        ST_ISSUE_ENG    = 2'd2,
        ST_HOST_RD_WAIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } host_op_t;

    localparam int REQ_HOST = 0;
    localparam int REQ_ENG  = 1;

endpackage

// File: rtl/jtag_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register and one-hot
// grant; after reset requester 1 counts as last granted, so requester 0 wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last_gnt;

    always_comb begin
        // NOTE: give gnt a default before any condition so no latch is inferred.
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (take && (req != 2'b00)) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/jtag_mem_arbiter.sv
// Arbitrates a single-ported memory between a pointer-based JTAG host port
// (1-deep pending slot) and a level-request engine port, round-robin on contention.
module jtag_mem_arbiter
    import jtag_mem_arbiter_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_addr_load,
    input  logic [AW-1:0] host_addr,
    input  logic          host_wr_req,
    input  logic [DW-1:0] host_wr_data,
    input  logic          host_rd_req,
    output logic [DW-1:0] host_rd_data,
    output logic          host_rd_valid,
    output logic          host_busy,
    output logic          host_err,
    input  logic          eng_req,
    input  logic          eng_we,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_wdata,
    output logic          eng_gnt,
    output logic [DW-1:0] eng_rdata,
    output logic          eng_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state, state_nxt;
    host_op_t      slot_op;
    logic [AW-1:0] slot_addr;
    logic [DW-1:0] slot_data;
    logic [AW-1:0] ptr;

    logic          slot_full, host_req, host_accept, host_drop, slot_clr;
    logic [AW-1:0] req_addr;
    logic [1:0]    arb_req, arb_gnt;

    assign slot_full   = (slot_op != OP_NONE);
    assign host_req    = host_wr_req | host_rd_req;
    assign host_accept = host_req & ~(host_wr_req & host_rd_req) & ~slot_full;
    assign host_drop   = host_req & ~host_accept;
    assign req_addr    = host_addr_load ? host_addr : ptr;
    assign slot_clr    = ((state == ST_ISSUE_HOST) && (slot_op == OP_WR)) ||
                         (state == ST_HOST_RD_WAIT);

    // A request accepted this cycle competes immediately; the slot is loaded
    // on the same edge that enters ISSUE_HOST.
    assign arb_req[REQ_HOST] = slot_full | host_accept;
    assign arb_req[REQ_ENG]  = eng_req;

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rst  (rst),
        .req  (arb_req),
        .take (state == ST_IDLE),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arb_gnt[REQ_HOST])     state_nxt = ST_ISSUE_HOST;
                else if (arb_gnt[REQ_ENG]) state_nxt = ST_ISSUE_ENG;
            end
            ST_ISSUE_HOST:   state_nxt = (slot_op == OP_RD) ? ST_HOST_RD_WAIT : ST_IDLE;
            ST_ISSUE_ENG:    state_nxt = ST_IDLE;
            ST_HOST_RD_WAIT: state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            // NOTE: slot payload is reset as well so no stale address/data survives a reset.
            slot_op       <= OP_NONE;
            slot_addr     <= '0;
            slot_data     <= '0;
            ptr           <= '0;
            host_err      <= 1'b0;
            host_rd_data  <= '0;
            host_rd_valid <= 1'b0;
            eng_rvalid    <= 1'b0;
        end else begin
            state         <= state_nxt;
            host_rd_valid <= (state == ST_HOST_RD_WAIT);
            eng_rvalid    <= (state == ST_ISSUE_ENG) && !eng_we;

            if (host_drop) host_err <= 1'b1;

            if (host_accept) begin
                slot_op   <= host_wr_req ? OP_WR : OP_RD;
                slot_addr <= req_addr;
                slot_data <= host_wr_data;
            end else if (slot_clr) begin
                slot_op   <= OP_NONE;
            end

            // A fresh load takes precedence over the post-issue increment.
            if (host_addr_load)              ptr <= host_addr;
            else if (state == ST_ISSUE_HOST) ptr <= ptr + AW'(1);

            if (state == ST_HOST_RD_WAIT) host_rd_data <= mem_rdata;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_ISSUE_HOST: begin
                mem_en    = 1'b1;
                mem_we    = (slot_op == OP_WR);
                mem_addr  = slot_addr;
                mem_wdata = slot_data;
            end
            ST_ISSUE_ENG: begin
                mem_en    = 1'b1;
                mem_we    = eng_we;
                mem_addr  = eng_addr;
                mem_wdata = eng_wdata;
            end
            default: ;
        endcase
    end

    assign eng_gnt   = (state == ST_ISSUE_ENG);
    assign eng_rdata = mem_rdata;
    assign host_busy = slot_full || (state != ST_IDLE);

endmodule
